fc_rx_credit_buffer: RTL and testbench
======================================

# fc_rx_credit_buffer

Parametrised receive-side flow-control buffer for one PCIe FC credit type (PH/PD/NPH/NPD/CPLH/CPLD), one credit per entry. Stores incoming TLP words in a first-word-fall-through FIFO. Tracks CREDITS_ALLOCATED and CREDITS_RECEIVED as modulo-2^FIELD_WIDTH counters and flags receiver overflow. Generates InitFC/UpdateFC advertisements toward the DLLP transmitter over a req/ack handshake. Six instances (one per FC type) sit between the TLP demux and the transaction layer consumers.

## Interface
- DATA_WIDTH, 160: width of one stored word
- DEPTH, 64: entries = credits advertised; power of two, 2 ≤ DEPTH ≤ 2^(FIELD_WIDTH-1)
- FIELD_WIDTH, 8: credit field width (8 header, 12 data)
- FC_TYPE, 3'b000: type code prepended to advertisements
- UPDATE_THRESHOLD, 4: freed credits that force an UpdateFC; 1..DEPTH
- UPDATE_TIMEOUT, 1024: cycles a pending update may wait before forced; ≥2
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- wr_valid  in  1  one TLP word arrives; no back-pressure
- wr_data  in  DATA_WIDTH  arriving word
- rd_valid  out  1  head entry valid (FWFT)
- rd_data  out  DATA_WIDTH  head entry
- rd_ready  in  1  consumer pops head when rd_valid & rd_ready
- count  out  $clog2(DEPTH)+1  occupied entries
- credits_allocated  out  FIELD_WIDTH  CA counter
- credits_received  out  FIELD_WIDTH  CR counter
- fc_update_req  out  1  advertisement pending
- fc_update  out  FIELD_WIDTH+3  {FC_TYPE, CA snapshot}
- fc_update_ack  in  1  transmitter took advertisement
- overflow_err  out  1  sticky receiver-overflow flag

## Operation
- Reset: pointers, count, CR = 0; CA = DEPTH mod 2^FIELD_WIDTH; rd_valid 0; rd_data 0; fc_update_req 0; fc_update {FC_TYPE, CA reset value}; overflow_err 0; FSM in INIT.
- Write: wr_valid while count < DEPTH stores word at wr_ptr, increments wr_ptr, count, and CR (mod 2^FIELD_WIDTH).
- Write while count == DEPTH (registered value): word dropped; CR and count unchanged; overflow_err set, held until reset. This is the spec check (CA − CR) mod 2^FIELD_WIDTH == 0 on arrival.
- Pop: rd_valid & rd_ready advances rd_ptr, decrements count, increments CA by 1 (mod 2^FIELD_WIDTH), and increments the freed counter.
- Simultaneous write and pop: count unchanged. If count == DEPTH at the start of the cycle, the write is still dropped (no bypass).
- Pointers wrap at DEPTH. CA/CR wrap naturally at 2^FIELD_WIDTH. Invariant: (CA − CR) mod 2^FIELD_WIDTH == DEPTH − count.
- FSM:
  - INIT: req=1 with reset CA (InitFC). On ack → IDLE; clears freed and timer.
  - IDLE: req=0. While freed > 0, the timer counts each cycle. → REQ when freed ≥ UPDATE_THRESHOLD, or timer == UPDATE_TIMEOUT−1, or count reaches 0 with freed > 0.
  - REQ: req=1. fc_update latches {FC_TYPE, CA} on entry and is stable until ack. On ack → IDLE; freed is reduced by the credits covered by the snapshot, and the timer is cleared.
- Pops during REQ accumulate into freed for the next advertisement. They never alter the snapshot being offered.

## Timing
- Write-to-rd_valid latency: 1 cycle (word written at edge N is visible after edge N). rd_data is a registered head.
- fc_update_req rises the edge after the trigger condition. It falls the edge after the ack cycle, so an ack in the first req cycle yields a 1-cycle req.
- ack sampled only while req=1; ack when req=0 is ignored.
- count, CA, CR, overflow_err update on the same edge as the write or pop.
- Asynchronous reset mid-handshake drops req immediately. The FSM returns to INIT and re-advertises the full DEPTH.

## Configuration
- FC_INFINITE_CREDIT_EN defined:
  - INIT advertises {FC_TYPE, 0} (infinite credit).
  - No UpdateFC is generated after INIT; the FSM stays in IDLE.
  - overflow_err is tied 0, and writes while full are dropped silently.
  - CA/CR still count.
- Not defined: finite-credit behaviour above.

## Test plan
- DEPTH=8, FIELD_WIDTH=8. Reset, then ack the first req → fc_update = {FC_TYPE, 8'd8}; req falls next cycle; count 0; CR 0.
- 8 writes, no pops → count 8, CR 8, rd_valid 1, head = first word. 9th write → dropped, overflow_err 1, CR stays 8, data order intact on drain.
- Full FIFO, UPDATE_THRESHOLD=4, 4 pops → req rises 1 cycle after 4th pop with fc_update CA = 12. Ack → IDLE.
- 1 pop, UPDATE_TIMEOUT=16, no further activity → req rises after 16 cycles with CA+1. Pops during REQ are advertised in the following update.
- Simultaneous write+pop at count 8 → write dropped, overflow_err 1. At count 5 → count stays 5, CA and CR each +1.
- 300 write/pop pairs with FIELD_WIDTH=8 → CA and CR wrap through 255→0; (CA−CR) mod 256 == 8 − count every cycle.
- With FC_INFINITE_CREDIT_EN → InitFC field 0; no further req over 100 pops; overflow_err stays 0.

Source files
------------

// File: rtl/fc_rx_credit_buffer.sv
// Receive-side flow-control credit buffer for one PCIe FC type: FWFT store, CA/CR tracking, InitFC/UpdateFC generation.
// Optional build macro FC_INFINITE_CREDIT_EN advertises infinite credit and suppresses UpdateFC and overflow reporting.
module fc_rx_credit_buffer #(
  parameter int unsigned DATA_WIDTH       = 160,
  parameter int unsigned DEPTH            = 64,
  parameter int unsigned FIELD_WIDTH      = 8,
  parameter logic [2:0]  FC_TYPE          = 3'b000,
  parameter int unsigned UPDATE_THRESHOLD = 4,
  parameter int unsigned UPDATE_TIMEOUT   = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_valid,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      rd_valid,
  output logic [DATA_WIDTH-1:0]     rd_data,
  input  logic                      rd_ready,
  output logic [$clog2(DEPTH):0]    count,
  output logic [FIELD_WIDTH-1:0]    credits_allocated,
  output logic [FIELD_WIDTH-1:0]    credits_received,
  output logic                      fc_update_req,
  output logic [FIELD_WIDTH+2:0]    fc_update,
  input  logic                      fc_update_ack,
  output logic                      overflow_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(UPDATE_TIMEOUT);
  localparam logic [FIELD_WIDTH-1:0] CA_RST = FIELD_WIDTH'(DEPTH);
`ifdef FC_INFINITE_CREDIT_EN
  localparam logic [FIELD_WIDTH-1:0] INIT_ADV = '0;
`else
  localparam logic [FIELD_WIDTH-1:0] INIT_ADV = CA_RST;
`endif

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_REQ} state_e;

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [FIELD_WIDTH-1:0] ca_q, cr_q, adv_q, adv_d, freed_c;
  logic                   rd_valid_q, ovf_q;
  logic [DATA_WIDTH-1:0]  rd_data_q, head_d;
  logic                   full_c, wr_en_c, pop_c;
  state_e                 state_q, state_d;
  logic                   req_q, req_d;
  logic [FIELD_WIDTH+2:0] upd_q, upd_d;
  logic [TW-1:0]          timer_q, timer_d;

  assign full_c   = (count_q == CW'(DEPTH));
  assign wr_en_c  = wr_valid && !full_c;
  assign pop_c    = rd_valid_q && rd_ready;
  assign count_d  = count_q + CW'(wr_en_c) - CW'(pop_c);
  assign rd_ptr_d = pop_c ? rd_ptr_q + PW'(1) : rd_ptr_q;
  // New head bypasses the array when it is the word being written this cycle.
  assign head_d   = (wr_en_c && (wr_ptr_q == rd_ptr_d)) ? wr_data : mem_q[rd_ptr_d];
  assign freed_c  = ca_q - adv_q;

  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ca_q       <= CA_RST;
      cr_q       <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (wr_en_c) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        cr_q     <= cr_q + FIELD_WIDTH'(1);
      end
      if (pop_c) ca_q <= ca_q + FIELD_WIDTH'(1);
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= (count_d != '0);
      if (count_d != '0) rd_data_q <= head_d;
`ifndef FC_INFINITE_CREDIT_EN
      if (wr_valid && full_c) ovf_q <= 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      req_q   <= 1'b0;
      upd_q   <= {FC_TYPE, INIT_ADV};
      adv_q   <= CA_RST;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      upd_q   <= upd_d;
      adv_q   <= adv_d;
      timer_q <= timer_d;
    end
  end

  // Advertisement FSM; adv_q is the CA value last acknowledged, so freed = CA - adv.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    upd_d   = upd_q;
    adv_d   = adv_q;
    timer_d = timer_q;
    case (state_q)
      ST_INIT: begin
        req_d = 1'b1;
        if (req_q && fc_update_ack) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          adv_d   = ca_q;
          timer_d = '0;
        end
      end
      ST_IDLE: begin
        req_d = 1'b0;
`ifndef FC_INFINITE_CREDIT_EN
        if (freed_c != '0) timer_d = timer_q + TW'(1);
        if ((freed_c >= FIELD_WIDTH'(UPDATE_THRESHOLD)) ||
            ((freed_c != '0) && (timer_q == TW'(UPDATE_TIMEOUT - 1))) ||
            ((freed_c != '0) && (count_q == '0))) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          upd_d   = {FC_TYPE, ca_q};
        end
`endif
      end
      ST_REQ: begin
        req_d = 1'b1;
        if (fc_update_ack) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          adv_d   = upd_q[FIELD_WIDTH-1:0];
          timer_d = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign rd_valid          = rd_valid_q;
  assign rd_data           = rd_data_q;
  assign count             = count_q;
  assign credits_allocated = ca_q;
  assign credits_received  = cr_q;
  assign fc_update_req     = req_q;
  assign fc_update         = upd_q;
  assign overflow_err      = ovf_q;

endmodule

// File: tb/tb_fc_rx_credit_buffer.sv
// Directed + random bench for fc_rx_credit_buffer against a queue-based credit model.
module tb_fc_rx_credit_buffer;
  localparam int unsigned DW = 32, DEPTH = 8, FW = 8, THR = 4, TO = 16;
  localparam logic [2:0] FT = 3'b101;
`ifdef FC_INFINITE_CREDIT_EN
  localparam bit INF = 1'b1;
`else
  localparam bit INF = 1'b0;
`endif

  logic          clk, rst_n, wr_valid, rd_valid, rd_ready, fc_update_req, fc_update_ack, overflow_err;
  logic [DW-1:0] wr_data, rd_data;
  logic [3:0]    count;
  logic [FW-1:0] credits_allocated, credits_received;
  logic [FW+2:0] fc_update;

  fc_rx_credit_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FIELD_WIDTH(FW), .FC_TYPE(FT),
                        .UPDATE_THRESHOLD(THR), .UPDATE_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready), .count(count),
    .credits_allocated(credits_allocated), .credits_received(credits_received),
    .fc_update_req(fc_update_req), .fc_update(fc_update),
    .fc_update_ack(fc_update_ack), .overflow_err(overflow_err));

  always #5 clk = ~clk;

  int n_chk, n_fail;

  // Reference model: stored words, credit counters, advertisement bookkeeping
  logic [DW-1:0] m_q[$];
  int m_ca, m_cr, m_upd, m_adv, m_timer;
  bit m_ovf, m_req, m_init;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_ca = DEPTH; m_cr = 0; m_ovf = 0; m_req = 0; m_init = 1;
    m_upd = INF ? 0 : DEPTH; m_adv = DEPTH; m_timer = 0;
  endtask

  task automatic check_all();
    logic [FW+2:0] exp_upd;
    exp_upd = {FT, FW'(m_upd)};
    chk("count", 64'(count), 64'(m_q.size()));
    chk("ca", 64'(credits_allocated), 64'(m_ca));
    chk("cr", 64'(credits_received), 64'(m_cr));
    chk("rd_valid", 64'(rd_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) chk("rd_data", 64'(rd_data), 64'(m_q[0]));
    chk("req", 64'(fc_update_req), 64'(m_req));
    chk("fc_update", 64'(fc_update), 64'(exp_upd));
    chk("overflow", 64'(overflow_err), 64'(m_ovf));
    chk("invariant", 64'(FW'(credits_allocated - credits_received)), 64'(DEPTH - int'(count)));
  endtask

  // One clock: drive inputs, advance model from pre-edge state, check after the edge
  task automatic step(input bit wr, input bit rdy, input bit ack);
    logic [DW-1:0] d;
    int freed, told;
    bit pop, full;
    d = $urandom;
    wr_valid = wr; wr_data = d; rd_ready = rdy; fc_update_ack = ack;
    pop   = rdy && (m_q.size() > 0);
    full  = (m_q.size() == DEPTH);
    freed = (m_ca - m_adv) & 255;
    told  = m_timer;
    if (wr && full && !INF) m_ovf = 1;
    if (m_req && ack) begin
      m_adv = m_init ? m_ca : m_upd;
      m_init = 0; m_req = 0; m_timer = 0;
    end else if (m_init) begin
      m_req = 1;
    end else if (!m_req && !INF) begin
      if (freed > 0) m_timer = told + 1;
      if (freed >= THR || (freed > 0 && told == TO - 1) || (freed > 0 && m_q.size() == 0)) begin
        m_req = 1; m_upd = m_ca;
      end
    end
    if (pop) begin void'(m_q.pop_front()); m_ca = (m_ca + 1) & 255; end
    if (wr && !full) begin m_q.push_back(d); m_cr = (m_cr + 1) & 255; end
    @(posedge clk); #1;
    check_all();
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    clk = 0; rst_n = 0; wr_valid = 0; wr_data = '0; rd_ready = 0; fc_update_ack = 0;
    m_reset();
    #12;
    check_all();
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    rst_n = 1;

    // InitFC and ack; ack while idle is ignored
    step(0, 0, 0);
    chk("initfc", 64'(fc_update), 64'({FT, (INF ? 8'd0 : 8'd8)}));
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);

    // Fill, then overflow write
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0);
    step(1, 0, 0);
    chk("ovf_after_9th", 64'(overflow_err), 64'(!INF));

    // Threshold-triggered UpdateFC
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    step(0, 0, 0);
`ifndef FC_INFINITE_CREDIT_EN
    chk("thr_upd", 64'(fc_update), 64'({FT, 8'd12}));
`endif
    step(0, 0, 0);
    step(0, 1, 1);

    // Timeout-triggered UpdateFC, pops during REQ deferred
    for (int i = 0; i < TO; i++) step(0, 0, 0);
    chk("timeout_req", 64'(fc_update_req), 64'(!INF));
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, m_req);

    // Simultaneous write+pop when full, then at count 5
    for (int i = 0; i < 40 && m_q.size() < DEPTH; i++) step(1, 0, m_req);
    step(1, 1, 0);
    chk("full_wp_count", 64'(count), 64'(DEPTH - 1));
    for (int i = 0; i < 40 && m_q.size() > 5; i++) step(0, 1, m_req);
    step(1, 1, 0);
    chk("wp5_count", 64'(count), 64'd5);

    // Long write/pop pairs drive CA/CR through wrap
    for (int i = 0; i < 300; i++) step(1, 1, m_req && ($urandom_range(0, 2) == 0));
    // Random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), m_req && ($urandom_range(0, 3) == 0));
    // Drain to empty
    for (int i = 0; i < 40; i++) step(0, 1, m_req);

    // Asynchronous reset mid-handshake
    for (int i = 0; i < 40 && !m_req; i++) step(0, 0, 0);
    #2 rst_n = 0;
    #1;
    m_reset();
    chk("rst_drops_req", 64'(fc_update_req), 64'd0);
    check_all();
    #3 rst_n = 1;
    step(0, 0, 0);
    chk("re_initfc", 64'(fc_update), 64'({FT, (INF ? 8'd0 : 8'd8)}));
    step(0, 0, 1);
    for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), m_req);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
